// File: rtl/ifetch_unit_pkg.sv
// Shared types for the instruction fetch slice: word type, fetch FSM states,
// pc/req_addr update selects and the instruction-size incrementer.
package ifetch_unit_pkg;

    typedef logic [15:0] lc3b_word;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,   // read outstanding, result will be delivered
        S_HOLD  = 2'd1,   // instruction held for control
        S_FLUSH = 2'd2    // read outstanding, result will be discarded
    } lc3b_fetch_state;

    localparam lc3b_word LC3B_INSN_BYTES = 16'd2;

    // Next-value selects for the pc register
    typedef enum logic [1:0] {
        PC_KEEP  = 2'd0,
        PC_INC   = 2'd1,  // req_addr + 2
        PC_REDIR = 2'd2   // redirect target
    } pc_sel_e;

    // Next-value selects for the request address register
    typedef enum logic [1:0] {
        REQ_KEEP  = 2'd0,
        REQ_PC    = 2'd1,
        REQ_REDIR = 2'd2
    } req_sel_e;

    // Sequential instruction address; wraps modulo 2^16
    function automatic lc3b_word insn_inc(input lc3b_word a);
        return a + LC3B_INSN_BYTES;
    endfunction

    // Instructions are word aligned; drop the byte bit
    function automatic lc3b_word word_align(input lc3b_word a);
        return {a[15:1], 1'b0};
    endfunction

endpackage

// File: rtl/ifetch_unit_pc_gen.sv
// pc / req_addr register pair with +2 incrementer and aligned redirect mux.
module fetch_pc_gen
    import ifetch_unit_pkg::*;
#(
    parameter lc3b_word RESET_PC = 16'h0000
) (
    input  logic     clk,
    input  logic     reset,
    input  pc_sel_e  pc_sel,
    input  req_sel_e req_sel,
    input  lc3b_word redirect_pc,
    output lc3b_word pc,
    output lc3b_word req_addr
);

    localparam lc3b_word BASE_PC = {RESET_PC[15:1], 1'b0};

    lc3b_word redir_tgt;
    lc3b_word inc_addr;

    assign redir_tgt = word_align(redirect_pc);
    assign inc_addr  = insn_inc(req_addr);

    // Update next-fetch pc and the address currently presented to memory
    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= BASE_PC;
            req_addr <= BASE_PC;
        end else begin
            case (pc_sel)
                PC_INC:   pc <= inc_addr;
                PC_REDIR: pc <= redir_tgt;
                default:  pc <= pc;
            endcase
            case (req_sel)
                REQ_PC:    req_addr <= pc;
                REQ_REDIR: req_addr <= redir_tgt;
                default:   req_addr <= req_addr;
            endcase
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch engine: reads instruction memory, pulses ir_load with the
// returned word, holds it for control and handles redirects, including one
// arriving while a read is in flight (that read is then flushed).
module ifetch_unit
    import ifetch_unit_pkg::*;
#(
    parameter lc3b_word RESET_PC = 16'h0000
) (
    input  logic     clk,
    input  logic     reset,
    output lc3b_word mem_address,
    output logic     mem_read,
    input  lc3b_word mem_rdata,
    input  logic     mem_resp,
    output logic     ir_load,
    output lc3b_word ir_data,
    output logic     fetch_valid,
    input  logic     fetch_ready,
    output lc3b_word fetch_pc,
    output lc3b_word next_pc,
    input  logic     redirect,
    input  lc3b_word redirect_pc
);

    lc3b_fetch_state state;
    lc3b_word        pc;
    lc3b_word        req_addr;
    lc3b_word        hold_word;
    pc_sel_e         pc_sel;
    req_sel_e        req_sel;

    fetch_pc_gen #(.RESET_PC(RESET_PC)) u_pc_gen (
        .clk         (clk),
        .reset       (reset),
        .pc_sel      (pc_sel),
        .req_sel     (req_sel),
        .redirect_pc (redirect_pc),
        .pc          (pc),
        .req_addr    (req_addr)
    );

    assign mem_address = req_addr;
    assign next_pc     = insn_inc(fetch_pc);

    // Deliver the word in its response cycle unless a redirect kills it
    assign ir_load = !reset && (state == S_FETCH) && mem_resp && !redirect;
    assign ir_data = ir_load ? mem_rdata : hold_word;

    // Address register steering for each state/event combination
    always_comb begin
        pc_sel  = PC_KEEP;
        req_sel = REQ_KEEP;
        case (state)
            S_FETCH: begin
                if (mem_resp && !redirect) begin
                    pc_sel = PC_INC;
                end else if (mem_resp && redirect) begin
                    pc_sel  = PC_REDIR;
                    req_sel = REQ_REDIR;
                end else if (redirect) begin
                    // keep presenting the in-flight address until it completes
                    pc_sel = PC_REDIR;
                end
            end
            S_FLUSH: begin
                if (redirect) pc_sel = PC_REDIR;
                if (mem_resp) req_sel = redirect ? REQ_REDIR : REQ_PC;
            end
            S_HOLD: begin
                if (redirect) begin
                    pc_sel  = PC_REDIR;
                    req_sel = REQ_REDIR;
                end else if (fetch_ready) begin
                    req_sel = REQ_PC;
                end
            end
            default: begin
                pc_sel  = PC_KEEP;
                req_sel = REQ_KEEP;
            end
        endcase
    end

    // Fetch FSM with registered mem_read / fetch_valid and held instruction
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_FETCH;
            mem_read    <= 1'b1;
            fetch_valid <= 1'b0;
            fetch_pc    <= '0;
            hold_word   <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (mem_resp && !redirect) begin
                        hold_word   <= mem_rdata;
                        fetch_pc    <= req_addr;
                        state       <= S_HOLD;
                        mem_read    <= 1'b0;
                        fetch_valid <= 1'b1;
                    end else if (!mem_resp && redirect) begin
                        state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (mem_resp) state <= S_FETCH;
                end
                S_HOLD: begin
                    if (redirect || fetch_ready) begin
                        state       <= S_FETCH;
                        mem_read    <= 1'b1;
                        fetch_valid <= 1'b0;
                    end
                end
                default: begin
                    state       <= S_FETCH;
                    mem_read    <= 1'b1;
                    fetch_valid <= 1'b0;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    // A word can only be delivered out of a live fetch
    a_ir_load_state: assert property (@(posedge clk) ir_load |-> (state == S_FETCH));

    // Requested address is stable for the life of a read
    a_addr_stable: assert property (@(posedge clk)
        ($past(mem_read) && !$past(mem_resp) && !$past(reset) && mem_read)
            |-> (mem_address == $past(mem_address)));
`endif

endmodule
